estagio_busca: RTL and testbench
================================

Name: estagio_busca

Overview:
Instruction-fetch stage that sits directly upstream of the control unit and register-bank stages. It owns the program counter and a loadable instruction memory, and presents one 8-bit instruction per cycle with a valid/ready handshake. It computes the next PC from the jump / beq / zero redirect signals returned by the execute stage. It stops fetching on the halt opcode (1111) or on an out-of-range PC.

Parameters:
LARGURA_END, 8, PC and address width in bits.
PROFUNDIDADE, 64, instruction memory depth in words (must be ≤ 2^LARGURA_END).
VETOR_INICIO, 0, PC value loaded by reset and by inicia.

Ports:
clock  in  1  single system clock; all state updates on posedge.
reset  in  1  asynchronous, active-low reset.
carrega_en  in  1  program-load write strobe.
carrega_end  in  LARGURA_END  program-load address.
carrega_dado  in  8  program-load data.
inicia  in  1  start / restart request.
pronto  in  1  downstream ready to consume instrucao.
jump  in  1  unconditional redirect for the instruction being consumed.
beq  in  1  conditional redirect for the instruction being consumed.
zero  in  1  branch condition from the ALU.
desvio  in  LARGURA_END  branch offset, added modulo 2^LARGURA_END.
instrucao  out  8  registered instruction word.
pc_atual  out  LARGURA_END  address of instrucao.
instrucao_valida  out  1  instrucao is valid.
parado  out  1  halted.
erro_end  out  1  sticky out-of-range PC flag.

Behaviour:
- States: OCIOSO, BUSCA, PARADO.
- reset low, at any time including mid-operation, takes effect immediately (asynchronous):
  - state=OCIOSO, pc_atual=VETOR_INICIO, instrucao=8'h00.
  - instrucao_valida=0, parado=0, erro_end=0.
  - Memory contents are preserved.
- Program load:
  - In OCIOSO or PARADO, carrega_en=1 writes mem[carrega_end]<=carrega_dado on posedge.
  - The write is ignored if carrega_end ≥ PROFUNDIDADE.
  - carrega_en is ignored in BUSCA.
- Start:
  - inicia=1 in OCIOSO or PARADO at edge T0 → state=BUSCA, pc=VETOR_INICIO, valida=0, parado=0. erro_end is not cleared.
  - At edge T1: instrucao<=mem[VETOR_INICIO], valida=1.
  - inicia is ignored in BUSCA.
- Handshake:
  - Consume occurs when valida && pronto at a posedge.
  - While valida && !pronto, instrucao and pc_atual hold unchanged.
  - jump, beq, zero and desvio are sampled only on consume edges.
- Next PC on consume:
  - npc = pc+1+desvio if (jump || (beq && zero)); otherwise npc = pc+1.
  - All arithmetic wraps modulo 2^LARGURA_END.
  - On the consume edge: pc<=npc, instrucao<=mem[npc], valida stays 1. Throughput is one instruction per cycle; there are no bubbles.
- Halt:
  - If the consumed instrucao[7:4]==4'b1111, jump/beq are ignored.
  - State=PARADO, valida=0, parado=1, and pc holds the halt address.
  - Only reset or inicia leaves PARADO.
- Out of range:
  - If the npc on a consume edge, or VETOR_INICIO at T1, is ≥ PROFUNDIDADE, no read occurs.
  - erro_end<=1 (sticky until reset), state=PARADO, parado=1, valida=0, pc<=that address.
- A halt opcode takes precedence over redirect.
- Memory is never read outside BUSCA.

Test Plan:
1. Reset:
   - Stimulus: pull reset low mid-BUSCA with no clock edge.
   - Required: instrucao=00, valida=0, parado=0, erro_end=0, pc_atual=0 immediately. After release, a preloaded mem[0] is still intact.
2. Sequential run:
   - Stimulus: load mem[0..3]=98,99,9A,F0; pulse inicia; hold pronto=1.
   - Required: valida rises at T1 with instrucao=98, pc=0; then 99/1, 9A/2, F0/3 on consecutive cycles. Next edge: parado=1, valida=0, pc=3.
3. Stall:
   - Stimulus: pronto=0 for 3 cycles while instrucao=99, pc=1.
   - Required: instrucao and pc hold for 3 cycles; after pronto=1, 9A appears on the next edge.
4. Redirects (desvio is sampled on the consume edge):
   - Consume at pc=1 with beq=1, zero=1, desvio=2 → pc=4.
   - Same with zero=0 → pc=2.
   - jump=1, desvio=FE at pc=5 → pc=4 (wrap).
   - F0 consumed with jump=1 → halt, no redirect.
5. Out of range (PROFUNDIDADE=64):
   - Stimulus: program with no halt; consume at pc=63.
   - Required: erro_end=1, parado=1, valida=0, pc=64. erro_end stays 1 after inicia and clears only on reset.
6. Load gating:
   - Stimulus: carrega_en during BUSCA, then a load in PARADO followed by inicia.
   - Required: the BUSCA write leaves memory unchanged. The PARADO load is executed from VETOR_INICIO after inicia.

Source files
------------

// File: rtl/estagio_busca.sv
// Instruction-fetch stage: owns the PC and a loadable instruction memory, hands one
// instruction per cycle downstream over valid/ready and stops on halt or a bad PC.
module estagio_busca #(
  parameter int unsigned LARGURA_END  = 8,
  parameter int unsigned PROFUNDIDADE = 64,
  parameter int unsigned VETOR_INICIO = 0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   carrega_en,
  input  logic [LARGURA_END-1:0] carrega_end,
  input  logic [7:0]             carrega_dado,
  input  logic                   inicia,
  input  logic                   pronto,
  input  logic                   jump,
  input  logic                   beq,
  input  logic                   zero,
  input  logic [LARGURA_END-1:0] desvio,
  output logic [7:0]             instrucao,
  output logic [LARGURA_END-1:0] pc_atual,
  output logic                   instrucao_valida,
  output logic                   parado,
  output logic                   erro_end,
  output logic [1:0]             estado_dbg
);

  // Handshake: a word is consumed on a posedge where instrucao_valida && pronto;
  // while valid and not ready, instrucao and pc_atual hold.

  localparam int unsigned IW = (PROFUNDIDADE > 1) ? $clog2(PROFUNDIDADE) : 1;
  localparam logic [LARGURA_END-1:0] VETOR = LARGURA_END'(VETOR_INICIO);
  localparam logic [LARGURA_END-1:0] UM    = LARGURA_END'(1);

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    BUSCA  = 2'd1,
    PARADO = 2'd2
  } estado_t;

  estado_t                estado_q;
  logic [7:0]             instrucao_q;
  logic [LARGURA_END-1:0] pc_q;
  logic                   valida_q;
  logic                   parado_q;
  logic                   erro_q;

  logic [7:0]             mem [PROFUNDIDADE];

  logic                   redireciona;
  logic                   eh_halt;
  logic [LARGURA_END-1:0] pc_d;
  logic [LARGURA_END-1:0] end_leitura;
  logic                   leitura_ok;
  logic [7:0]             instrucao_d;

  function automatic logic em_faixa(input logic [LARGURA_END-1:0] a);
    return 32'(a) < PROFUNDIDADE;
  endfunction

  always_comb begin
    redireciona = jump || (beq && zero);
    eh_halt     = (instrucao_q[7:4] == 4'b1111);
    pc_d        = pc_q + UM + (redireciona ? desvio : '0);
    // First fetch after inicia reads at pc_q; every later fetch reads at the next PC.
    end_leitura = valida_q ? pc_d : pc_q;
    leitura_ok  = (estado_q == BUSCA) && em_faixa(end_leitura);
    instrucao_d = 8'h00;
    if (leitura_ok) instrucao_d = mem[end_leitura[IW-1:0]];
  end

  // Program memory has no reset so a loaded program survives reset.
  always_ff @(posedge clock) begin
    if (carrega_en && (estado_q != BUSCA) && em_faixa(carrega_end))
      mem[carrega_end[IW-1:0]] <= carrega_dado;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q    <= OCIOSO;
      instrucao_q <= 8'h00;
      pc_q        <= VETOR;
      valida_q    <= 1'b0;
      parado_q    <= 1'b0;
      erro_q      <= 1'b0;
    end else begin
      case (estado_q)
        OCIOSO, PARADO: begin
          if (inicia) begin
            estado_q <= BUSCA;
            pc_q     <= VETOR;
            valida_q <= 1'b0;
            parado_q <= 1'b0;
          end
        end
        BUSCA: begin
          if (!valida_q) begin
            if (em_faixa(pc_q)) begin
              instrucao_q <= instrucao_d;
              valida_q    <= 1'b1;
            end else begin
              erro_q   <= 1'b1;
              estado_q <= PARADO;
              parado_q <= 1'b1;
            end
          end else if (pronto) begin
            // Halt wins over any redirect and leaves the PC on the halt word.
            if (eh_halt) begin
              estado_q <= PARADO;
              valida_q <= 1'b0;
              parado_q <= 1'b1;
            end else if (em_faixa(pc_d)) begin
              pc_q        <= pc_d;
              instrucao_q <= instrucao_d;
            end else begin
              pc_q     <= pc_d;
              erro_q   <= 1'b1;
              estado_q <= PARADO;
              valida_q <= 1'b0;
              parado_q <= 1'b1;
            end
          end
        end
        default: estado_q <= OCIOSO;
      endcase
    end
  end

  assign instrucao        = instrucao_q;
  assign pc_atual         = pc_q;
  assign instrucao_valida = valida_q;
  assign parado           = parado_q;
  assign erro_end         = erro_q;
  assign estado_dbg       = estado_q;

endmodule

// File: tb/tb_estagio_busca.sv
// Directed bench for estagio_busca: load, sequential run, stall, redirects,
// out-of-range stop, asynchronous reset and load gating.
module tb_estagio_busca;

  logic       clock;
  logic       reset;
  logic       carrega_en;
  logic [7:0] carrega_end;
  logic [7:0] carrega_dado;
  logic       inicia;
  logic       pronto;
  logic       jump;
  logic       beq;
  logic       zero;
  logic [7:0] desvio;
  logic [7:0] instrucao;
  logic [7:0] pc_atual;
  logic       instrucao_valida;
  logic       parado;
  logic       erro_end;
  logic [1:0] estado_dbg;

  int checks = 0;
  int errors = 0;

  estagio_busca #(
    .LARGURA_END (8),
    .PROFUNDIDADE(64),
    .VETOR_INICIO(0)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .carrega_en      (carrega_en),
    .carrega_end     (carrega_end),
    .carrega_dado    (carrega_dado),
    .inicia          (inicia),
    .pronto          (pronto),
    .jump            (jump),
    .beq             (beq),
    .zero            (zero),
    .desvio          (desvio),
    .instrucao       (instrucao),
    .pc_atual        (pc_atual),
    .instrucao_valida(instrucao_valida),
    .parado          (parado),
    .erro_end        (erro_end),
    .estado_dbg      (estado_dbg)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic load(input logic [7:0] a, input logic [7:0] d);
    carrega_en   = 1'b1;
    carrega_end  = a;
    carrega_dado = d;
    step();
    carrega_en   = 1'b0;
  endtask

  // Pulse inicia and advance to T1, where the first word should be valid.
  task automatic start_run();
    inicia = 1'b1;
    step();
    inicia = 1'b0;
    step();
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (instrucao !== 8'h00) begin errors++; $display("FAIL reset_instr: got %h exp 00", instrucao); end
    checks++;
    if (instrucao_valida !== 1'b0 || parado !== 1'b0 || erro_end !== 1'b0) begin
      errors++; $display("FAIL reset_flags: got v%b p%b e%b exp 000", instrucao_valida, parado, erro_end);
    end
    checks++;
    if (pc_atual !== 8'h00 || estado_dbg !== 2'd0) begin
      errors++; $display("FAIL reset_pc_state: got pc %h st %0d exp 00/0", pc_atual, estado_dbg);
    end
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic test_sequential();
    logic [7:0] ei [4];
    ei = '{8'h98, 8'h99, 8'h9A, 8'hF0};
    for (int i = 0; i < 4; i++) load(8'(i), ei[i]);
    pronto = 1'b1;
    inicia = 1'b1;
    step();
    inicia = 1'b0;
    checks++;
    if (instrucao_valida !== 1'b0 || estado_dbg !== 2'd1) begin
      errors++; $display("FAIL seq_t0: got v%b st %0d exp v0 st 1", instrucao_valida, estado_dbg);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (instrucao !== ei[i] || pc_atual !== 8'(i) || instrucao_valida !== 1'b1) begin
        errors++;
        $display("FAIL seq_word%0d: got %h/%h v%b exp %h/%h v1", i, instrucao, pc_atual, instrucao_valida, ei[i], 8'(i));
      end
    end
    step();
    checks++;
    if (parado !== 1'b1 || instrucao_valida !== 1'b0 || pc_atual !== 8'h03) begin
      errors++; $display("FAIL seq_halt: got p%b v%b pc %h exp p1 v0 pc 03", parado, instrucao_valida, pc_atual);
    end
  endtask

  task automatic test_stall();
    pronto = 1'b0;
    start_run();
    pronto = 1'b1;
    step();
    pronto = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (instrucao !== 8'h99 || pc_atual !== 8'h01 || instrucao_valida !== 1'b1) begin
        errors++; $display("FAIL stall_hold%0d: got %h/%h v%b exp 99/01 v1", i, instrucao, pc_atual, instrucao_valida);
      end
    end
    pronto = 1'b1;
    step();
    checks++;
    if (instrucao !== 8'h9A || pc_atual !== 8'h02) begin
      errors++; $display("FAIL stall_release: got %h/%h exp 9A/02", instrucao, pc_atual);
    end
    step();
    step();
    checks++;
    if (parado !== 1'b1) begin errors++; $display("FAIL stall_halt: got parado %b exp 1", parado); end
  endtask

  task automatic test_redirects();
    logic [7:0] prog [7];
    prog = '{8'h10, 8'h20, 8'h30, 8'hF0, 8'h50, 8'h60, 8'hF0};
    for (int i = 0; i < 7; i++) load(8'(i), prog[i]);
    pronto = 1'b1;
    start_run();
    step();
    beq = 1'b1; zero = 1'b1; desvio = 8'h02;
    step();
    beq = 1'b0; zero = 1'b0; desvio = 8'h00;
    checks++;
    if (pc_atual !== 8'h04 || instrucao !== 8'h50) begin
      errors++; $display("FAIL beq_taken: got %h/%h exp 04/50", pc_atual, instrucao);
    end
    step();
    jump = 1'b1; desvio = 8'hFE;
    step();
    jump = 1'b0; desvio = 8'h00;
    checks++;
    if (pc_atual !== 8'h04 || instrucao !== 8'h50) begin
      errors++; $display("FAIL jump_wrap: got %h/%h exp 04/50", pc_atual, instrucao);
    end
    step();
    step();
    checks++;
    if (pc_atual !== 8'h06 || instrucao !== 8'hF0) begin
      errors++; $display("FAIL reach_halt: got %h/%h exp 06/F0", pc_atual, instrucao);
    end
    jump = 1'b1; desvio = 8'h05;
    step();
    jump = 1'b0; desvio = 8'h00;
    checks++;
    if (parado !== 1'b1 || instrucao_valida !== 1'b0 || pc_atual !== 8'h06) begin
      errors++; $display("FAIL halt_over_jump: got p%b v%b pc %h exp p1 v0 pc 06", parado, instrucao_valida, pc_atual);
    end
    start_run();
    step();
    beq = 1'b1; zero = 1'b0; desvio = 8'h02;
    step();
    beq = 1'b0; desvio = 8'h00;
    checks++;
    if (pc_atual !== 8'h02 || instrucao !== 8'h30) begin
      errors++; $display("FAIL beq_not_taken: got %h/%h exp 02/30", pc_atual, instrucao);
    end
    step();
    step();
    checks++;
    if (parado !== 1'b1 || pc_atual !== 8'h03) begin
      errors++; $display("FAIL beq_run_halt: got p%b pc %h exp p1 pc 03", parado, pc_atual);
    end
  endtask

  task automatic test_out_of_range();
    load(8'h00, 8'h11);
    for (int i = 1; i < 64; i++) load(8'(i), 8'h00);
    pronto = 1'b1;
    start_run();
    for (int i = 0; i < 63; i++) step();
    checks++;
    if (pc_atual !== 8'd63 || instrucao_valida !== 1'b1 || erro_end !== 1'b0) begin
      errors++; $display("FAIL oor_last: got pc %h v%b e%b exp 3F v1 e0", pc_atual, instrucao_valida, erro_end);
    end
    step();
    checks++;
    if (erro_end !== 1'b1 || parado !== 1'b1 || instrucao_valida !== 1'b0 || pc_atual !== 8'd64) begin
      errors++; $display("FAIL oor_stop: got e%b p%b v%b pc %h exp e1 p1 v0 pc 40", erro_end, parado, instrucao_valida, pc_atual);
    end
    pronto = 1'b0;
    start_run();
    checks++;
    if (erro_end !== 1'b1 || instrucao !== 8'h11 || parado !== 1'b0) begin
      errors++; $display("FAIL oor_sticky: got e%b instr %h p%b exp e1 11 p0", erro_end, instrucao, parado);
    end
  endtask

  task automatic test_async_reset();
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (instrucao !== 8'h00 || instrucao_valida !== 1'b0 || parado !== 1'b0 ||
        erro_end !== 1'b0 || pc_atual !== 8'h00) begin
      errors++;
      $display("FAIL async_reset: got %h v%b p%b e%b pc %h exp 00 v0 p0 e0 pc 00",
               instrucao, instrucao_valida, parado, erro_end, pc_atual);
    end
    #1;
    reset = 1'b1;
    step();
    start_run();
    checks++;
    if (instrucao !== 8'h11 || instrucao_valida !== 1'b1) begin
      errors++; $display("FAIL mem_kept: got %h v%b exp 11 v1", instrucao, instrucao_valida);
    end
  endtask

  task automatic test_load_gating();
    bit done;
    load(8'h02, 8'h77);
    pronto = 1'b1;
    step();
    step();
    checks++;
    if (pc_atual !== 8'h02 || instrucao !== 8'h00) begin
      errors++; $display("FAIL busca_write_ignored: got %h/%h exp 02/00", pc_atual, instrucao);
    end
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      step();
      if (parado === 1'b1) done = 1'b1;
    end
    checks++;
    if (!done) begin errors++; $display("FAIL gate_wait_parado: got timeout exp parado within 100 cycles"); end
    pronto = 1'b0;
    load(8'h00, 8'hA1);
    load(8'h01, 8'hF0);
    load(8'h40, 8'hEE);
    start_run();
    checks++;
    if (instrucao !== 8'hA1 || pc_atual !== 8'h00 || instrucao_valida !== 1'b1) begin
      errors++; $display("FAIL parado_load: got %h/%h v%b exp A1/00 v1", instrucao, pc_atual, instrucao_valida);
    end
    pronto = 1'b1;
    step();
    checks++;
    if (instrucao !== 8'hF0 || pc_atual !== 8'h01) begin
      errors++; $display("FAIL parado_load_w1: got %h/%h exp F0/01", instrucao, pc_atual);
    end
    step();
    checks++;
    if (parado !== 1'b1 || pc_atual !== 8'h01) begin
      errors++; $display("FAIL parado_load_halt: got p%b pc %h exp p1 pc 01", parado, pc_atual);
    end
  endtask

  initial begin
    reset = 1'b0;
    carrega_en = 1'b0; carrega_end = 8'h00; carrega_dado = 8'h00;
    inicia = 1'b0; pronto = 1'b0;
    jump = 1'b0; beq = 1'b0; zero = 1'b0; desvio = 8'h00;
    test_reset();
    test_sequential();
    test_stall();
    test_redirects();
    test_out_of_range();
    test_async_reset();
    test_load_gating();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
